// File: rtl/lsu_prf_wb_arb_mp_pkg.sv
// Shared LSU writeback parameters and small helpers used by the PRF writeback arbiter.
package lsu_prf_wb_arb_mp_pkg;

  localparam int LSU_DATA_PIPE_COUNT = 2;
  localparam int LSU_WB_FIFO_DEPTH   = 4;
  localparam int PHY_REG_ADDR_WIDTH  = 6;
  localparam int XLEN                = 64;

  // $clog2 that never returns 0, so single-entry selectors still get a 1-bit vector
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/lsu_wb_src_fifo.sv
// Per-source writeback buffer: circular FIFO with registered count, ready = not full.
module lsu_wb_src_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 71
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         rdy,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign rdy     = (count < CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & rdy & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/lsu_prf_wb_arb_mp.sv
// Multi-port PRF writeback arbiter: buffers each LSU source and grants up to
// WB_PORT_COUNT non-empty sources per cycle in round-robin order.
module lsu_prf_wb_arb_mp
  import lsu_prf_wb_arb_mp_pkg::*;
#(
  parameter int SRC_COUNT          = lsu_prf_wb_arb_mp_pkg::LSU_DATA_PIPE_COUNT + 1,
  parameter int WB_PORT_COUNT      = 2,
  parameter int FIFO_DEPTH         = lsu_prf_wb_arb_mp_pkg::LSU_WB_FIFO_DEPTH,
  parameter int PHY_REG_ADDR_WIDTH = lsu_prf_wb_arb_mp_pkg::PHY_REG_ADDR_WIDTH,
  parameter int XLEN               = lsu_prf_wb_arb_mp_pkg::XLEN
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       flush,
  input  logic [SRC_COUNT-1:0]                       src_vld_i,
  input  logic [SRC_COUNT*PHY_REG_ADDR_WIDTH-1:0]    src_rd_addr_i,
  input  logic [SRC_COUNT-1:0]                       src_is_float_i,
  input  logic [SRC_COUNT*XLEN-1:0]                  src_data_i,
  output logic [SRC_COUNT-1:0]                       src_rdy_o,
  output logic [WB_PORT_COUNT-1:0]                   prf_wb_vld_o,
  input  logic [WB_PORT_COUNT-1:0]                   prf_wb_rdy_i,
  output logic [WB_PORT_COUNT*PHY_REG_ADDR_WIDTH-1:0] prf_wb_rd_addr_o,
  output logic [WB_PORT_COUNT-1:0]                   prf_wb_is_float_o,
  output logic [WB_PORT_COUNT*XLEN-1:0]              prf_wb_data_o,
  output logic                                       arb_idle_o
);

  localparam int AW = PHY_REG_ADDR_WIDTH;
  localparam int EW = AW + 1 + XLEN;
  localparam int SW = clog2_min1(SRC_COUNT);

  logic [EW-1:0]        head [SRC_COUNT];
  logic [SRC_COUNT-1:0] empty;
  logic [SRC_COUNT-1:0] pop;
  logic [SRC_COUNT-1:0] sel [WB_PORT_COUNT];
  logic [SW-1:0]        rr_ptr;
  logic [SW-1:0]        rr_nxt;
  logic                 any_pop;
  int                   off  [SRC_COUNT];
  int                   rank [SRC_COUNT];
  int                   best;

  for (genvar s = 0; s < SRC_COUNT; s++) begin : g_src
    lsu_wb_src_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (EW)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (src_vld_i[s]),
      .din   ({src_rd_addr_i[s*AW +: AW], src_is_float_i[s], src_data_i[s*XLEN +: XLEN]}),
      .pop   (pop[s]),
      .dout  (head[s]),
      .rdy   (src_rdy_o[s]),
      .empty (empty[s])
    );
  end

  // Each non-empty source's port is the number of non-empty sources ahead of it in scan order
  always_comb begin
    for (int s = 0; s < SRC_COUNT; s++) begin
      off[s] = s - int'(rr_ptr);
      if (off[s] < 0) off[s] = off[s] + SRC_COUNT;
    end
    for (int s = 0; s < SRC_COUNT; s++) begin
      rank[s] = 0;
      for (int t = 0; t < SRC_COUNT; t++) begin
        if (!empty[t] && (off[t] < off[s])) rank[s] = rank[s] + 1;
      end
    end
    for (int k = 0; k < WB_PORT_COUNT; k++) begin
      sel[k] = '0;
      for (int s = 0; s < SRC_COUNT; s++) begin
        if (!empty[s] && (rank[s] == k) && !flush) sel[k][s] = 1'b1;
      end
    end
  end

  // The pointer follows the furthest dequeued source in scan order
  always_comb begin
    pop     = '0;
    any_pop = 1'b0;
    rr_nxt  = rr_ptr;
    best    = -1;
    for (int k = 0; k < WB_PORT_COUNT; k++) begin
      for (int s = 0; s < SRC_COUNT; s++) begin
        if (sel[k][s] && prf_wb_rdy_i[k]) begin
          pop[s]  = 1'b1;
          any_pop = 1'b1;
          if (off[s] > best) begin
            best   = off[s];
            rr_nxt = SW'((s + 1) % SRC_COUNT);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (flush) begin
      rr_ptr <= '0;
    end else if (any_pop) begin
      rr_ptr <= rr_nxt;
    end
  end

  always_comb begin
    prf_wb_vld_o      = '0;
    prf_wb_rd_addr_o  = '0;
    prf_wb_is_float_o = '0;
    prf_wb_data_o     = '0;
    for (int k = 0; k < WB_PORT_COUNT; k++) begin
      for (int s = 0; s < SRC_COUNT; s++) begin
        if (sel[k][s]) begin
          prf_wb_vld_o[k]                = 1'b1;
          prf_wb_rd_addr_o[k*AW +: AW]   = head[s][EW-1 -: AW];
          prf_wb_is_float_o[k]           = head[s][XLEN];
          prf_wb_data_o[k*XLEN +: XLEN]  = head[s][XLEN-1:0];
        end
      end
    end
  end

  assign arb_idle_o = &empty;

endmodule

// File: tb/tb_lsu_prf_wb_arb_mp.sv
// Bench for lsu_prf_wb_arb_mp: directed scenarios plus random traffic, scored by a queue model.
module tb_lsu_prf_wb_arb_mp;

  localparam int SRC   = 3;
  localparam int WB    = 2;
  localparam int DEPTH = 4;
  localparam int AW    = 6;
  localparam int XL    = 64;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 flush = 1'b0;
  logic [SRC-1:0]       src_vld_i = '0;
  logic [SRC*AW-1:0]    src_rd_addr_i = '0;
  logic [SRC-1:0]       src_is_float_i = '0;
  logic [SRC*XL-1:0]    src_data_i = '0;
  logic [SRC-1:0]       src_rdy_o;
  logic [WB-1:0]        prf_wb_vld_o;
  logic [WB-1:0]        prf_wb_rdy_i = '0;
  logic [WB*AW-1:0]     prf_wb_rd_addr_o;
  logic [WB-1:0]        prf_wb_is_float_o;
  logic [WB*XL-1:0]     prf_wb_data_o;
  logic                 arb_idle_o;

  lsu_prf_wb_arb_mp #(
    .SRC_COUNT          (SRC),
    .WB_PORT_COUNT      (WB),
    .FIFO_DEPTH         (DEPTH),
    .PHY_REG_ADDR_WIDTH (AW),
    .XLEN               (XL)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .src_vld_i         (src_vld_i),
    .src_rd_addr_i     (src_rd_addr_i),
    .src_is_float_i    (src_is_float_i),
    .src_data_i        (src_data_i),
    .src_rdy_o         (src_rdy_o),
    .prf_wb_vld_o      (prf_wb_vld_o),
    .prf_wb_rdy_i      (prf_wb_rdy_i),
    .prf_wb_rd_addr_o  (prf_wb_rd_addr_o),
    .prf_wb_is_float_o (prf_wb_is_float_o),
    .prf_wb_data_o     (prf_wb_data_o),
    .arb_idle_o        (arb_idle_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [AW-1:0] a;
    logic          f;
    logic [XL-1:0] d;
  } ent_t;

  // Reference model: one queue of expected writebacks per source plus a round-robin start
  ent_t mq [SRC][$];
  int   rr_m = 0;

  always @(negedge clk) begin : monitor
    int             n;
    int             sidx;
    int             last;
    int             gsrc [WB];
    logic [SRC-1:0] exp_rdy;
    logic           exp_idle;
    logic [71:0]    act_p;
    logic [71:0]    exp_p;
    ent_t           e;
    if (rst) begin
      chk("rst_rdy", 128'(src_rdy_o), 128'({SRC{1'b1}}));
      chk("rst_vld", 128'(prf_wb_vld_o), 128'(0));
      chk("rst_idle", 128'(arb_idle_o), 128'(1));
      for (int s = 0; s < SRC; s++) mq[s].delete();
      rr_m = 0;
    end else begin
      n = 0;
      for (int i = 0; i < SRC; i++) begin
        sidx = (rr_m + i) % SRC;
        if (mq[sidx].size() > 0 && n < WB) begin
          gsrc[n] = sidx;
          n++;
        end
      end
      for (int k = 0; k < WB; k++) begin
        act_p = {prf_wb_vld_o[k], prf_wb_rd_addr_o[k*AW +: AW], prf_wb_is_float_o[k],
                 prf_wb_data_o[k*XL +: XL]};
        if (flush) begin
          chk($sformatf("flush_vld_p%0d", k), 128'(prf_wb_vld_o[k]), 128'(0));
        end else begin
          if (k < n) begin
            e = mq[gsrc[k]][0];
            exp_p = {1'b1, e.a, e.f, e.d};
          end else begin
            exp_p = '0;
          end
          chk($sformatf("port%0d", k), 128'(act_p), 128'(exp_p));
        end
      end
      exp_idle = 1'b1;
      for (int s = 0; s < SRC; s++) begin
        exp_rdy[s] = (mq[s].size() < DEPTH);
        if (mq[s].size() != 0) exp_idle = 1'b0;
      end
      chk("src_rdy", 128'(src_rdy_o), 128'(exp_rdy));
      chk("idle", 128'(arb_idle_o), 128'(exp_idle));
      if (flush) begin
        for (int s = 0; s < SRC; s++) mq[s].delete();
        rr_m = 0;
      end else begin
        last = -1;
        for (int k = 0; k < n; k++) begin
          if (prf_wb_rdy_i[k]) begin
            void'(mq[gsrc[k]].pop_front());
            last = gsrc[k];
          end
        end
        if (last >= 0) rr_m = (last + 1) % SRC;
        for (int s = 0; s < SRC; s++) begin
          if (src_vld_i[s] && exp_rdy[s]) begin
            e.a = src_rd_addr_i[s*AW +: AW];
            e.f = src_is_float_i[s];
            e.d = src_data_i[s*XL +: XL];
            mq[s].push_back(e);
          end
        end
      end
    end
  end

  // Source tag lives in the top byte of data so a writeback can be traced to its source
  task automatic drive(input logic [SRC-1:0] v, input logic [WB-1:0] r, input logic fl);
    @(posedge clk);
    #1;
    src_vld_i    = v;
    prf_wb_rdy_i = r;
    flush        = fl;
    for (int s = 0; s < SRC; s++) begin
      src_rd_addr_i[s*AW +: AW] = AW'($urandom);
      src_is_float_i[s]         = 1'($urandom);
      src_data_i[s*XL +: XL]    = {8'(s), 24'($urandom), 32'($urandom)};
    end
  endtask

  int exp_seq [4] = '{0, 1, 2, 0};

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("post_rst_rdy", 128'(src_rdy_o), 128'(3'b111));
    chk("post_rst_vld", 128'(prf_wb_vld_o), 128'(0));
    chk("post_rst_idle", 128'(arb_idle_o), 128'(1));

    // three sources, one entry each, both ports ready
    drive(3'b111, 2'b11, 1'b0);
    src_rd_addr_i = {6'd3, 6'd2, 6'd1};
    drive(3'b000, 2'b11, 1'b0);
    #1;
    chk("c1_p0", 128'({prf_wb_vld_o[0], prf_wb_rd_addr_o[5:0]}), 128'({1'b1, 6'd1}));
    chk("c1_p1", 128'({prf_wb_vld_o[1], prf_wb_rd_addr_o[11:6]}), 128'({1'b1, 6'd2}));
    drive(3'b000, 2'b11, 1'b0);
    #1;
    chk("c2_p0", 128'({prf_wb_vld_o[0], prf_wb_rd_addr_o[5:0]}), 128'({1'b1, 6'd3}));
    chk("c2_p1_vld", 128'(prf_wb_vld_o[1]), 128'(0));
    drive(3'b000, 2'b11, 1'b0);
    #1;
    chk("c3_idle", 128'({arb_idle_o, prf_wb_vld_o}), 128'({1'b1, 2'b00}));

    // source 0 fills its buffer while the PRF stalls
    repeat (4) drive(3'b001, 2'b00, 1'b0);
    drive(3'b001, 2'b00, 1'b0);
    #1 chk("full_rdy0", 128'(src_rdy_o[0]), 128'(0));
    drive(3'b001, 2'b01, 1'b0);
    #1 chk("full_rdy0_deq", 128'(src_rdy_o[0]), 128'(0));
    drive(3'b001, 2'b00, 1'b0);
    #1 chk("refill_rdy0", 128'(src_rdy_o[0]), 128'(1));
    drive(3'b000, 2'b00, 1'b0);
    #1 chk("refull_rdy0", 128'(src_rdy_o[0]), 128'(0));
    repeat (5) drive(3'b000, 2'b11, 1'b0);

    // round-robin rotation through a single ready port
    drive(3'b000, 2'b00, 1'b1);
    repeat (3) drive(3'b111, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(3'b000, 2'b01, 1'b0);
      #1;
      chk($sformatf("rr_grant%0d", i), 128'({prf_wb_vld_o[0], prf_wb_data_o[63:56]}),
          128'({1'b1, 8'(exp_seq[i])}));
    end
    repeat (4) drive(3'b000, 2'b11, 1'b0);

    // flush with buffered data
    repeat (2) drive(3'b111, 2'b00, 1'b0);
    drive(3'b000, 2'b11, 1'b1);
    #1 chk("flush_cyc_vld", 128'(prf_wb_vld_o), 128'(0));
    drive(3'b000, 2'b11, 1'b0);
    #1 chk("post_flush", 128'({arb_idle_o, prf_wb_vld_o}), 128'({1'b1, 2'b00}));

    // asynchronous reset in the middle of a burst
    repeat (2) drive(3'b111, 2'b00, 1'b0);
    drive(3'b000, 2'b11, 1'b0);
    #1 chk("pre_rst_vld", 128'(prf_wb_vld_o), 128'(2'b11));
    rst = 1'b1;
    #1 chk("async_rst", 128'({arb_idle_o, prf_wb_vld_o}), 128'({1'b1, 2'b00}));
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("post_async_rst", 128'({arb_idle_o, prf_wb_vld_o}), 128'({1'b1, 2'b00}));

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      drive(SRC'($urandom), WB'($urandom), ($urandom_range(0, 49) == 0));
    end
    repeat (10) drive(3'b000, 2'b11, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
